// File: rtl/screen_scan.sv
// screen_scan: 640x480@60 VGA raster generator that fetches Hack screen words
// and serialises them into a centred 512x256 window with a coloured border.
module screen_scan #(
    parameter int unsigned PIX_DIV = 2,
    parameter logic [11:0] BORDER  = 12'h222
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    output logic [12:0] oSCR_ADDR,
    input  logic [15:0] iSCR,
    output logic        oVGA_HS_n,
    output logic        oVGA_VS_n,
    output logic [3:0]  oVGA_R,
    output logic [3:0]  oVGA_G,
    output logic [3:0]  oVGA_B,
    output logic        oDE,
    output logic        oFRAME
);

    localparam int unsigned DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned H_W    = 10;
    localparam int unsigned V_W    = 10;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned RGB_W  = 12;

    localparam logic [H_W-1:0] H_LAST     = 10'd799;
    localparam logic [V_W-1:0] V_LAST     = 10'd524;
    localparam logic [H_W-1:0] H_VIS_END  = 10'd640;
    localparam logic [V_W-1:0] V_VIS_END  = 10'd480;
    localparam logic [H_W-1:0] H_SYNC_ON  = 10'd656;
    localparam logic [H_W-1:0] H_SYNC_OFF = 10'd751;
    localparam logic [V_W-1:0] V_SYNC_ON  = 10'd490;
    localparam logic [V_W-1:0] V_SYNC_OFF = 10'd491;
    localparam logic [H_W-1:0] WIN_X0     = 10'd64;
    localparam logic [H_W-1:0] WIN_X1     = 10'd575;
    localparam logic [V_W-1:0] WIN_Y0     = 10'd112;
    localparam logic [V_W-1:0] WIN_Y1     = 10'd367;
    // Fetch fires one pixel before each word's first pixel, load on it.
    localparam logic [H_W-1:0] FETCH_FIRST = 10'd62;
    localparam logic [H_W-1:0] FETCH_LAST  = 10'd558;
    localparam logic [H_W-1:0] LOAD_FIRST  = 10'd63;
    localparam logic [H_W-1:0] LOAD_LAST   = 10'd559;
    localparam logic [H_W-1:0] SHIFT_LAST  = 10'd574;

    localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;
    localparam logic [RGB_W-1:0] RGB_WHITE = 12'hFFF;

    logic [DIV_W-1:0]  divCnt;
    logic [H_W-1:0]    hCnt;
    logic [V_W-1:0]    vCnt;
    logic [WORD_W-1:0] shiftReg;

    logic              pixTick;
    logic              lineEnd;
    logic              frameEnd;
    logic              vInWin;
    logic              hInWin;
    logic              hVis;
    logic              vVis;
    logic [8:0]        hFetchOfs;
    logic [3:0]        hLoadOfs;
    logic [7:0]        vRow;
    logic              fetchHit;
    logic              loadHit;
    logic              shiftHit;
    logic [RGB_W-1:0]  pixColour;

    // Tick, wrap, window and fetch/load decode from the current counters.
    assign pixTick   = (divCnt == DIV_W'(PIX_DIV - 1));
    assign lineEnd   = (hCnt == H_LAST);
    assign frameEnd  = lineEnd && (vCnt == V_LAST);
    assign vInWin    = (vCnt >= WIN_Y0) && (vCnt <= WIN_Y1);
    assign hInWin    = (hCnt >= WIN_X0) && (hCnt <= WIN_X1);
    assign hVis      = (hCnt < H_VIS_END);
    assign vVis      = (vCnt < V_VIS_END);
    assign hFetchOfs = 9'(hCnt - FETCH_FIRST);
    assign hLoadOfs  = 4'(hCnt - LOAD_FIRST);
    assign vRow      = 8'(vCnt - WIN_Y0);
    assign fetchHit  = vInWin && (hCnt >= FETCH_FIRST) && (hCnt <= FETCH_LAST)
                       && (hFetchOfs[3:0] == 4'd0);
    assign loadHit   = (hCnt >= LOAD_FIRST) && (hCnt <= LOAD_LAST) && (hLoadOfs == 4'd0);
    assign shiftHit  = vInWin && (hCnt >= LOAD_FIRST) && (hCnt <= SHIFT_LAST);

    // Pixel colour for the position currently held in the counters.
    always_comb begin
        pixColour = RGB_BLACK;
        if (hVis && vVis) begin
            if (hInWin && vInWin) begin
                pixColour = shiftReg[0] ? RGB_BLACK : RGB_WHITE;
            end else begin
                pixColour = BORDER;
            end
        end
    end

    // Pixel-rate divider.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            divCnt <= '0;
        end else if (pixTick) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    // Horizontal and vertical raster counters.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (pixTick) begin
            if (lineEnd) begin
                hCnt <= '0;
                vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
            end else begin
                hCnt <= hCnt + 1'b1;
            end
        end
    end

    // Screen word address, issued one pixel ahead of the word's first pixel.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oSCR_ADDR <= '0;
        end else if (pixTick && fetchHit) begin
            oSCR_ADDR <= {vRow, hFetchOfs[8:4]};
        end
    end

    // Pixel shifter: a load at a word boundary wins over the shift.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            shiftReg <= '0;
        end else if (pixTick) begin
            if (loadHit) begin
                shiftReg <= iSCR;
            end else if (shiftHit) begin
                shiftReg <= {1'b0, shiftReg[WORD_W-1:1]};
            end
        end
    end

    // One-pixel output pipeline shared by sync, enable and colour.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oVGA_HS_n <= 1'b1;
            oVGA_VS_n <= 1'b1;
            oDE       <= 1'b0;
            oVGA_R    <= '0;
            oVGA_G    <= '0;
            oVGA_B    <= '0;
        end else if (pixTick) begin
            oVGA_HS_n <= !((hCnt >= H_SYNC_ON) && (hCnt <= H_SYNC_OFF));
            oVGA_VS_n <= !((vCnt >= V_SYNC_ON) && (vCnt <= V_SYNC_OFF));
            oDE       <= hVis && vVis;
            oVGA_R    <= pixColour[11:8];
            oVGA_G    <= pixColour[7:4];
            oVGA_B    <= pixColour[3:0];
        end
    end

    // Single-iCLK frame-start strobe following the wrap to (0,0).
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oFRAME <= 1'b0;
        end else begin
            oFRAME <= pixTick && frameEnd;
        end
    end

endmodule

// File: tb/tb_screen_scan.sv
// tb_screen_scan: raster/fetch/pixel checks of screen_scan against a position-based model.
module tb_screen_scan;

    localparam int unsigned PIX_DIV   = 2;
    localparam int unsigned H_TOTAL   = 800;
    localparam int unsigned V_TOTAL   = 525;
    localparam int unsigned FRAME_TK  = H_TOTAL * V_TOTAL;
    localparam logic [11:0] BORDER    = 12'h222;
    localparam int unsigned ERR_LIMIT = 40;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic [15:0] iSCR;
    logic [12:0] oSCR_ADDR;
    logic        oVGA_HS_n;
    logic        oVGA_VS_n;
    logic [3:0]  oVGA_R;
    logic [3:0]  oVGA_G;
    logic [3:0]  oVGA_B;
    logic        oDE;
    logic        oFRAME;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] screenMem [8192];

    screen_scan #(.PIX_DIV(PIX_DIV), .BORDER(BORDER)) dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .oSCR_ADDR (oSCR_ADDR),
        .iSCR      (iSCR),
        .oVGA_HS_n (oVGA_HS_n),
        .oVGA_VS_n (oVGA_VS_n),
        .oVGA_R    (oVGA_R),
        .oVGA_G    (oVGA_G),
        .oVGA_B    (oVGA_B),
        .oDE       (oDE),
        .oFRAME    (oFRAME)
    );

    always #10 iCLK = ~iCLK;

    // Screen memory read port: one iCLK of latency.
    always @(posedge iCLK) iSCR <= screenMem[oSCR_ADDR];

    task automatic chk(input string tag, input int unsigned cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference colour of a raster position straight from the screen image.
    function automatic logic [11:0] expColour(input int unsigned h, input int unsigned v);
        int unsigned x, y;
        logic [15:0] w;
        if (h >= 640 || v >= 480) return 12'h000;
        if (h >= 64 && h < 576 && v >= 112 && v < 368) begin
            x = h - 64;
            y = v - 112;
            w = screenMem[y * 32 + x / 16];
            return w[x % 16] ? 12'h000 : 12'hFFF;
        end
        return BORDER;
    endfunction

    task automatic checkResetVals(input string tag);
        chk({tag, "_hs"},   0, 32'(oVGA_HS_n), 32'd1);
        chk({tag, "_vs"},   0, 32'(oVGA_VS_n), 32'd1);
        chk({tag, "_rgb"},  0, 32'({oVGA_R, oVGA_G, oVGA_B}), 32'd0);
        chk({tag, "_de"},   0, 32'(oDE), 32'd0);
        chk({tag, "_addr"}, 0, 32'(oSCR_ADDR), 32'd0);
        chk({tag, "_frame"},0, 32'(oFRAME), 32'd0);
    endtask

    // Run from reset release, checking every iCLK against the position model.
    task automatic runSpan(input int unsigned cycles, input int unsigned expAddr32At,
                           input int unsigned expSteps);
        int unsigned n, p, q, h, v, hq, vq;
        int unsigned expAddr, hsLowAt, addr32At, addrSteps;
        logic [12:0] lastAddr;
        logic [11:0] eRgb, obsRgb;
        logic eHs, eVs, eDe, eFrame;
        expAddr   = 0;
        hsLowAt   = 0;
        addr32At  = 0;
        addrSteps = 0;
        lastAddr  = '0;
        for (int unsigned c = 1; c <= cycles; c++) begin
            if (errors > ERR_LIMIT) break;
            @(negedge iCLK);
            n = c / PIX_DIV;
            if ((c % PIX_DIV) == 0) begin
                q  = n;
                hq = q % H_TOTAL;
                vq = (q / H_TOTAL) % V_TOTAL;
                if (vq >= 112 && vq <= 367 && hq >= 63 && hq <= 559 && ((hq - 63) % 16) == 0)
                    expAddr = (vq - 112) * 32 + (hq - 63) / 16;
            end
            h = 0;
            v = 0;
            if (n == 0) begin
                eHs = 1'b1; eVs = 1'b1; eDe = 1'b0; eRgb = 12'h000;
            end else begin
                p    = n - 1;
                h    = p % H_TOTAL;
                v    = (p / H_TOTAL) % V_TOTAL;
                eHs  = !(h >= 656 && h <= 751);
                eVs  = !(v >= 490 && v <= 491);
                eDe  = (h < 640) && (v < 480);
                eRgb = expColour(h, v);
            end
            eFrame = ((c % PIX_DIV) == 0) && (n > 0) && ((n % FRAME_TK) == 0);
            obsRgb = {oVGA_R, oVGA_G, oVGA_B};
            chk("hs",    c, 32'(oVGA_HS_n), 32'(eHs));
            chk("vs",    c, 32'(oVGA_VS_n), 32'(eVs));
            chk("de",    c, 32'(oDE),       32'(eDe));
            chk("rgb",   c, 32'(obsRgb),    32'(eRgb));
            chk("addr",  c, 32'(oSCR_ADDR), expAddr);
            chk("frame", c, 32'(oFRAME),    32'(eFrame));
            if (n >= 1) begin
                if (v == 112 && h == 63)  chk("pix112_left_border", c, 32'(obsRgb), 32'h222);
                if (v == 112 && h == 64)  chk("pix112_x0_black",    c, 32'(obsRgb), 32'h000);
                if (v == 112 && h == 65)  chk("pix112_x1_white",    c, 32'(obsRgb), 32'hFFF);
                if (v == 112 && h == 575) chk("pix112_x511_white",  c, 32'(obsRgb), 32'hFFF);
                if (v == 112 && h == 576) chk("pix112_right_border",c, 32'(obsRgb), 32'h222);
                if (v == 113 && h == 94)  chk("pix113_x30_white",   c, 32'(obsRgb), 32'hFFF);
                if (v == 113 && h == 95)  chk("pix113_x31_black",   c, 32'(obsRgb), 32'h000);
                if (v == 113 && h == 96)  chk("pix113_x32_white",   c, 32'(obsRgb), 32'hFFF);
            end
            if (oVGA_HS_n == 1'b0 && hsLowAt == 0) hsLowAt = c;
            if (oSCR_ADDR == 13'd32 && addr32At == 0) addr32At = c;
            if (oSCR_ADDR != lastAddr) begin
                chk("addr_step", c, 32'(oSCR_ADDR), 32'(lastAddr) + 32'd1);
                lastAddr = oSCR_ADDR;
                addrSteps++;
            end
        end
        chk("hs_first_low_cycle", cycles, hsLowAt, 32'd1314);
        chk("addr32_issue_cycle", cycles, addr32At, expAddr32At);
        chk("addr_update_count",  cycles, addrSteps, expSteps);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++)
            screenMem[i] = (i < 64) ? 16'h0000 : 16'($urandom);
        screenMem[0]  = 16'h0001;
        screenMem[33] = 16'h8000;

        // Power-on reset.
        iRST_n = 1'b0;
        repeat (5) @(posedge iCLK);
        @(negedge iCLK);
        checkResetVals("reset");
        iRST_n = 1'b1;

        // Lines 0..115 plus part of line 116: sync, border and the first window rows.
        runSpan(2 * (116 * H_TOTAL + 300), 2 * (113 * H_TOTAL + 63), 142);

        // Asynchronous reset at (h,v) = (300,116).
        iRST_n = 1'b0;
        #1;
        checkResetVals("midreset_async");
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        checkResetVals("midreset_hold");
        iRST_n = 1'b1;

        // Raster restarts from (0,0) with no frame strobe.
        runSpan(2 * 2 * H_TOTAL, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
